// File: rtl/plab4_net_router_output_ctrl_tdm.sv
// Output-port control for the two-domain router: TDM domain slots, round-robin within the active domain.
// Latency: zero cycles from reqs to grants/sel/out_val; pointers and slot timer update at posedge.
// Backpressure: out_rdy=0 suppresses grants and freezes pointers; the slot timer keeps running.
module plab4_net_router_output_ctrl_tdm #(
    parameter int p_num_ins     = 3,
    parameter int p_slot_cycles = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [p_num_ins-1:0]                reqs,
    input  logic [p_num_ins-1:0]                req_domain,
    input  logic                                out_rdy,
    output logic [p_num_ins-1:0]                grants,
    output logic [$clog2(p_num_ins)-1:0]        sel,
    output logic                                out_val,
    output logic                                domain
);

    localparam int c_sel_nbits = $clog2(p_num_ins);
    localparam int c_cnt_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    localparam int c_sum_nbits = c_sel_nbits + 1;

    logic                       dom_q;
    logic [c_cnt_nbits-1:0]     slot_cnt;
    logic [c_sel_nbits-1:0]     rr_ptr_d0;
    logic [c_sel_nbits-1:0]     rr_ptr_d1;

    logic [p_num_ins-1:0]       elig;
    logic [c_sel_nbits-1:0]     ptr;
    logic [c_sel_nbits-1:0]     win;
    logic [c_sel_nbits-1:0]     win_next;
    logic [c_sum_nbits-1:0]     scan_sum;
    logic [c_sel_nbits-1:0]     scan_idx;
    logic                       found;
    logic                       grant_en;

    // Only requests tagged with the slot-owning domain may compete.
    assign elig = reqs & ~(req_domain ^ {p_num_ins{dom_q}});

    // Round-robin scan starting at the active domain's pointer; first eligible input wins.
    always_comb begin
        ptr      = dom_q ? rr_ptr_d1 : rr_ptr_d0;
        found    = 1'b0;
        win      = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < p_num_ins; k++) begin
            // ptr and k are both below p_num_ins, so one subtraction wraps the sum.
            scan_sum = {1'b0, ptr} + c_sum_nbits'(k);
            if (scan_sum >= c_sum_nbits'(p_num_ins)) begin
                scan_sum = scan_sum - c_sum_nbits'(p_num_ins);
            end
            scan_idx = scan_sum[c_sel_nbits-1:0];
            if (!found && elig[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    // Grant only when downstream is ready and never while reset is asserted.
    always_comb begin
        grant_en = found & out_rdy & ~reset;
        grants   = grant_en ? (p_num_ins'(1) << win) : '0;
        sel      = grant_en ? win : '0;
        out_val  = grant_en;
        domain   = dom_q;
        win_next = (win == c_sel_nbits'(p_num_ins - 1)) ? '0 : win + c_sel_nbits'(1);
    end

    // Free-running slot timer plus per-domain pointer update on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            dom_q     <= 1'b0;
            slot_cnt  <= '0;
            rr_ptr_d0 <= '0;
            rr_ptr_d1 <= '0;
        end else begin
            if (slot_cnt == c_cnt_nbits'(p_slot_cycles - 1)) begin
                slot_cnt <= '0;
                dom_q    <= ~dom_q;
            end else begin
                slot_cnt <= slot_cnt + c_cnt_nbits'(1);
            end
            if (grant_en) begin
                if (dom_q) begin
                    rr_ptr_d1 <= win_next;
                end else begin
                    rr_ptr_d0 <= win_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_tdm.sv
module tb_plab4_net_router_output_ctrl_tdm;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] reqs, req_domain;
    logic       out_rdy;
    logic [2:0] grants;
    logic [1:0] sel;
    logic       out_val, domain;

    logic [2:0] reqs1, req_domain1;
    logic       out_rdy1;
    logic [2:0] grants1;
    logic [1:0] sel1;
    logic       out_val1, domain1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    plab4_net_router_output_ctrl_tdm #(.p_num_ins(3), .p_slot_cycles(4)) u_dut (
        .clk(clk), .reset(reset), .reqs(reqs), .req_domain(req_domain), .out_rdy(out_rdy),
        .grants(grants), .sel(sel), .out_val(out_val), .domain(domain)
    );

    plab4_net_router_output_ctrl_tdm #(.p_num_ins(3), .p_slot_cycles(1)) u_dut1 (
        .clk(clk), .reset(reset), .reqs(reqs1), .req_domain(req_domain1), .out_rdy(out_rdy1),
        .grants(grants1), .sel(sel1), .out_val(out_val1), .domain(domain1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One reset edge, then release: the next cycle is cycle 0 of a domain-0 slot.
    task automatic do_reset;
        reqs = '0; req_domain = '0; out_rdy = 1'b1;
        reqs1 = '0; req_domain1 = '0; out_rdy1 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic ed;
        reset = 1'b1; reqs = 3'b111; req_domain = 3'b000; out_rdy = 1'b1;
        reqs1 = 3'b111; req_domain1 = 3'b000; out_rdy1 = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            n_cmp++;
            if (grants !== 3'b000 || out_val !== 1'b0 || sel !== 2'd0) begin
                n_err++;
                $display("FAIL reset_outputs r=%0d got g=%b v=%b s=%0d want g=000 v=0 s=0", r, grants, out_val, sel);
            end
            n_cmp++;
            if (domain !== 1'b0) begin
                n_err++;
                $display("FAIL reset_domain r=%0d got %b want 0", r, domain);
            end
            tick();
        end
        reset = 1'b0; reqs = '0; reqs1 = '0;
        for (int c = 0; c < 14; c++) begin
            ed = ((c / 4) % 2) != 0;
            @(negedge clk);
            n_cmp++;
            if (domain !== ed) begin
                n_err++;
                $display("FAIL slot_domain c=%0d got %b want %b", c, domain, ed);
            end
            tick();
        end
        // Now in cycle 14, mid domain-1 slot: reset with dom1 requests must block grants.
        reset = 1'b1; reqs = 3'b111; req_domain = 3'b111;
        @(negedge clk);
        n_cmp++;
        if (grants !== 3'b000) begin
            n_err++;
            $display("FAIL midslot_reset_grants got %b want 000", grants);
        end
        tick();
        reset = 1'b0; reqs = '0;
        for (int c = 0; c < 5; c++) begin
            ed = (c >= 4);
            @(negedge clk);
            n_cmp++;
            if (domain !== ed) begin
                n_err++;
                $display("FAIL midslot_domain c=%0d got %b want %b", c, domain, ed);
            end
            tick();
        end
    endtask

    task automatic test_rr_domain0;
        logic [2:0] eg [10];
        logic [1:0] es [10];
        eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100};
        es = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        do_reset();
        reqs = 3'b111; req_domain = 3'b000; out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (grants !== eg[c] || sel !== es[c] || out_val !== (|eg[c])) begin
                n_err++;
                $display("FAIL rr_dom0 c=%0d got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                         c, grants, sel, out_val, eg[c], es[c], |eg[c]);
            end
            tick();
        end
        reqs = '0;
    endtask

    task automatic test_isolation;
        logic [2:0] eg_b [12];
        logic [1:0] es_b [12];
        logic [2:0] eg_a;
        eg_b = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100,
                 3'b001, 3'b001, 3'b001, 3'b001};
        es_b = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        // Dom1 idle reference run.
        do_reset();
        reqs = 3'b001; req_domain = 3'b000;
        for (int c = 0; c < 12; c++) begin
            eg_a = (c < 4 || c >= 8) ? 3'b001 : 3'b000;
            @(negedge clk);
            n_cmp++;
            if (grants !== eg_a) begin
                n_err++;
                $display("FAIL iso_idle c=%0d got %b want %b", c, grants, eg_a);
            end
            tick();
        end
        // Dom1 flooded by inputs 1 and 2; input 0 grant times must not move.
        do_reset();
        reqs = 3'b111; req_domain = 3'b110;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if (grants !== eg_b[c] || sel !== es_b[c]) begin
                n_err++;
                $display("FAIL iso_flood c=%0d got g=%b s=%0d want g=%b s=%0d", c, grants, sel, eg_b[c], es_b[c]);
            end
            tick();
        end
        reqs = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        reqs = 3'b100; req_domain = 3'b000; out_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) out_rdy = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (c < 3 && (grants !== 3'b000 || out_val !== 1'b0 || sel !== 2'd0)) begin
                n_err++;
                $display("FAIL bp_stall c=%0d got g=%b v=%b s=%0d want g=000 v=0 s=0", c, grants, out_val, sel);
            end else if (c == 3 && (grants !== 3'b100 || sel !== 2'd2 || out_val !== 1'b1)) begin
                n_err++;
                $display("FAIL bp_release got g=%b s=%0d v=%b want g=100 s=2 v=1", grants, sel, out_val);
            end
            tick();
        end
        reqs = '0;
        for (int c = 4; c < 8; c++) tick();
        // Pointer sits at 0 after granting input 2; stalls must not advance it.
        reqs = 3'b111; out_rdy = 1'b0;
        for (int c = 8; c < 12; c++) begin
            if (c == 11) out_rdy = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (c < 11 && grants !== 3'b000) begin
                n_err++;
                $display("FAIL bp_stall2 c=%0d got %b want 000", c, grants);
            end else if (c == 11 && (grants !== 3'b001 || sel !== 2'd0)) begin
                n_err++;
                $display("FAIL bp_ptr_hold got g=%b s=%0d want g=001 s=0", grants, sel);
            end
            tick();
        end
        reqs = '0; out_rdy = 1'b1;
    endtask

    task automatic test_boundary;
        // Dom1 request raised in the last dom0 cycle waits for the dom1 slot.
        do_reset();
        for (int c = 0; c < 3; c++) tick();
        reqs = 3'b010; req_domain = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (grants !== 3'b000 || domain !== 1'b0) begin
            n_err++;
            $display("FAIL bnd_last_dom0 got g=%b d=%b want g=000 d=0", grants, domain);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (grants !== 3'b010 || sel !== 2'd1 || domain !== 1'b1) begin
            n_err++;
            $display("FAIL bnd_first_dom1 got g=%b s=%0d d=%b want g=010 s=1 d=1", grants, sel, domain);
        end
        tick();
        reqs = '0;
        // Grant in the last dom0 cycle: pointer update and domain toggle on the same edge.
        do_reset();
        for (int c = 0; c < 3; c++) tick();
        reqs = 3'b010; req_domain = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (grants !== 3'b010) begin
            n_err++;
            $display("FAIL bnd_last_grant got %b want 010", grants);
        end
        tick();
        reqs = '0;
        for (int c = 4; c < 8; c++) tick();
        reqs = 3'b111; req_domain = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (grants !== 3'b100 || sel !== 2'd2 || domain !== 1'b0) begin
            n_err++;
            $display("FAIL bnd_ptr_commit got g=%b s=%0d d=%b want g=100 s=2 d=0", grants, sel, domain);
        end
        tick();
        reqs = '0;
        for (int c = 9; c < 12; c++) tick();
        // Dom1 pointer untouched by all the dom0 activity.
        reqs = 3'b111; req_domain = 3'b111;
        @(negedge clk);
        n_cmp++;
        if (grants !== 3'b001 || domain !== 1'b1) begin
            n_err++;
            $display("FAIL bnd_dom1_ptr got g=%b d=%b want g=001 d=1", grants, domain);
        end
        tick();
        reqs = '0;
    endtask

    task automatic test_slot1;
        logic ed;
        do_reset();
        reqs1 = 3'b001; out_rdy1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ed = (c % 2) != 0;
            req_domain1 = (c < 8) ? {2'b00, ed} : {2'b00, ~ed};
            @(negedge clk);
            n_cmp++;
            if (domain1 !== ed) begin
                n_err++;
                $display("FAIL slot1_domain c=%0d got %b want %b", c, domain1, ed);
            end
            n_cmp++;
            if (c < 8 && (grants1 !== 3'b001 || sel1 !== 2'd0 || out_val1 !== 1'b1)) begin
                n_err++;
                $display("FAIL slot1_match c=%0d got g=%b v=%b want g=001 v=1", c, grants1, out_val1);
            end else if (c >= 8 && (grants1 !== 3'b000 || out_val1 !== 1'b0)) begin
                n_err++;
                $display("FAIL slot1_mismatch c=%0d got g=%b v=%b want g=000 v=0", c, grants1, out_val1);
            end
            tick();
        end
        reqs1 = '0;
    endtask

    initial begin
        reset = 1'b1;
        reqs = '0; req_domain = '0; out_rdy = 1'b0;
        reqs1 = '0; req_domain1 = '0; out_rdy1 = 1'b0;
        test_reset();
        test_rr_domain0();
        test_isolation();
        test_backpressure();
        test_boundary();
        test_slot1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
